// File: rtl/ddr2_v4_dqs_pkg.sv
// Shared types and constants for the DDR2 DQS write-burst controller.
// Holds the FSM state enum, the per-lane phase payload, toggle-count
// constants for BL4/BL8 and the shared down-counter width.
package ddr2_v4_dqs_pkg;

   localparam int unsigned CNT_W   = 3;
   localparam int unsigned BL4_TOG = 2;
   localparam int unsigned BL8_TOG = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRE    = 2'd1,
      ST_TOGGLE = 2'd2,
      ST_POST   = 2'd3
   } dqs_state_e;

   // Decoded burst phase handed to every lane driver.
   typedef struct packed {
      logic drive;   // PRE, TOGGLE or POST: lane output enabled
      logic toggle;  // TOGGLE: DQS released from its low hold
   } lane_phase_t;

   // Counter reload for the TOGGLE phase (counter runs duration-1 .. 0).
   function automatic logic [CNT_W-1:0] tog_reload(input logic bl8);
      return bl8 ? CNT_W'(BL8_TOG - 1) : CNT_W'(BL4_TOG - 1);
   endfunction

endpackage

// File: rtl/ddr2_v4_dqs_lane_drv.sv
// Output flops for one DQS lane.
// Ports: clk, reset (sync, active-low), phase (next burst phase),
//        mask (next captured mask bit), dqs_rst / dqs_oe_n (registered).
module ddr2_v4_dqs_lane_drv
   import ddr2_v4_dqs_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  lane_phase_t phase,
   input  logic        mask,
   output logic        dqs_rst,
   output logic        dqs_oe_n
);

   // Masked-off lanes stay tristated and held low.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dqs_oe_n <= 1'b1;
         dqs_rst  <= 1'b1;
      end else begin
         dqs_oe_n <= ~(phase.drive  & mask);
         dqs_rst  <= ~(phase.toggle & mask);
      end
   end

endmodule

// File: rtl/ddr2_v4_dqs_burst_ctrl.sv
// DDR2 DQS write-burst controller: sequences preamble, toggle and
// postamble phases per accepted write request across DQS_WIDTH lanes.
// Optional feature macro: DQS_BACK_TO_BACK_EN (chains a same-mask burst
// requested in the last toggle cycle without post/preamble).
// Ports: clk, reset (sync, active-low), wr_req, bl8, lane_mask (inputs);
//        wr_ack, busy, dqs_rst, dqs_oe_n (registered outputs).
module ddr2_v4_dqs_burst_ctrl
   import ddr2_v4_dqs_pkg::*;
#(
   parameter int unsigned DQS_WIDTH = 2,
   parameter int unsigned PRE_CYC   = 1,
   parameter int unsigned POST_CYC  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_req,
   input  logic                 bl8,
   input  logic [DQS_WIDTH-1:0] lane_mask,
   output logic                 wr_ack,
   output logic                 busy,
   output logic [DQS_WIDTH-1:0] dqs_rst,
   output logic [DQS_WIDTH-1:0] dqs_oe_n
);

   if (DQS_WIDTH < 1 || PRE_CYC < 1 || PRE_CYC > 7 ||
       POST_CYC < 1 || POST_CYC > 7) begin : g_param_err
      $error("ddr2_v4_dqs_burst_ctrl: illegal DQS_WIDTH/PRE_CYC/POST_CYC");
   end

   localparam logic [CNT_W-1:0] PRE_RLD  = CNT_W'(PRE_CYC - 1);
   localparam logic [CNT_W-1:0] POST_RLD = CNT_W'(POST_CYC - 1);

   dqs_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 bl8_q, bl8_d;
   logic [DQS_WIDTH-1:0] mask_q, mask_d;
   logic                 ack_d;
   lane_phase_t          phase_d;

   // Next-state, counter and capture logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bl8_d   = bl8_q;
      mask_d  = mask_q;
      ack_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wr_req) begin
               state_d = ST_PRE;
               cnt_d   = PRE_RLD;
               bl8_d   = bl8;
               mask_d  = lane_mask;
               ack_d   = 1'b1;
            end
         end
         ST_PRE: begin
            if (cnt_q == '0) begin
               state_d = ST_TOGGLE;
               cnt_d   = tog_reload(bl8_q);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_TOGGLE: begin
            if (cnt_q == '0) begin
`ifdef DQS_BACK_TO_BACK_EN
               // Same-mask request in the last toggle cycle extends the burst.
               if (wr_req && (lane_mask == mask_q)) begin
                  cnt_d = tog_reload(bl8);
                  bl8_d = bl8;
                  ack_d = 1'b1;
               end else begin
                  state_d = ST_POST;
                  cnt_d   = POST_RLD;
               end
`else
               state_d = ST_POST;
               cnt_d   = POST_RLD;
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_POST: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Lanes register the phase of the upcoming state so they switch with it.
   always_comb begin
      phase_d.drive  = (state_d != ST_IDLE);
      phase_d.toggle = (state_d == ST_TOGGLE);
   end

   // State, counter, captured request and status flops.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bl8_q   <= 1'b0;
         mask_q  <= '0;
         wr_ack  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bl8_q   <= bl8_d;
         mask_q  <= mask_d;
         wr_ack  <= ack_d;
         busy    <= (state_d != ST_IDLE);
      end
   end

   for (genvar i = 0; i < DQS_WIDTH; i++) begin : g_lane
      ddr2_v4_dqs_lane_drv u_lane (
         .clk      (clk),
         .reset    (reset),
         .phase    (phase_d),
         .mask     (mask_d[i]),
         .dqs_rst  (dqs_rst[i]),
         .dqs_oe_n (dqs_oe_n[i])
      );
   end

endmodule

// File: doc/ddr2_v4_dqs_burst_ctrl.md
DDR2_V4_DQS_BURST_CTRL -- requirements
Module: ddr2_v4_dqs_burst_ctrl

Interface
REQ-001 Parameter DQS_WIDTH, default 2: number of independent DQS lanes.
REQ-002 Parameter PRE_CYC, default 1: preamble length in clk cycles; legal range 1..7.
REQ-003 Parameter POST_CYC, default 1: postamble length in clk cycles; legal range 1..7.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 wr_req  input  1  write-burst request; level, held until wr_ack.
REQ-007 bl8  input  1  burst length select, sampled at accept: 0 = BL4 (2 toggle cycles), 1 = BL8 (4 toggle cycles).
REQ-008 lane_mask  input  DQS_WIDTH  lanes to drive, sampled at accept.
REQ-009 wr_ack  output  1  one-cycle pulse; request accepted.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 dqs_rst  output  DQS_WIDTH  per lane; 1 = hold DQS output low, 0 = toggle.
REQ-012 dqs_oe_n  output  DQS_WIDTH  per lane tristate control; 1 = hi-Z, 0 = driven.

Function
REQ-013 FSM states IDLE, PRE, TOGGLE, POST; all outputs registered (Moore, updated on the same edge as the state).
REQ-014 IDLE with wr_req=1 at edge k: at k, state=PRE, wr_ack=1, bl8 and lane_mask captured; wr_ack is 0 in every other cycle except REQ-022.
REQ-015 PRE lasts exactly PRE_CYC cycles, then TOGGLE; TOGGLE lasts 2 (BL4) or 4 (BL8) cycles, then POST; POST lasts exactly POST_CYC cycles, then IDLE.
REQ-016 Per lane i with captured mask bit 1: PRE -> oe_n=0, rst=1; TOGGLE -> oe_n=0, rst=0; POST -> oe_n=0, rst=1; IDLE -> oe_n=1, rst=1.
REQ-017 Lanes with captured mask bit 0 stay oe_n=1, rst=1 throughout.
REQ-018 lane_mask=0 accepted normally; FSM sequences full timing; no lane is driven.
REQ-019 wr_req while busy (outside REQ-022) not acked; the requester holds it; it is accepted on the first IDLE cycle (IDLE lasts at least 1 cycle between bursts).
REQ-020 One shared down-counter, width 3 bits; reloaded on every state entry; counter value never observable on outputs.
REQ-021 bl8, lane_mask changes while busy have no effect on the current burst.

Configuration
REQ-022 With DQS_BACK_TO_BACK_EN defined: wr_req=1 during last TOGGLE cycle with lane_mask equal to captured mask -> wr_ack=1, stay TOGGLE, reload counter with new bl8, no postamble/preamble; mask mismatch -> normal REQ-019 path.
REQ-023 Without DQS_BACK_TO_BACK_EN: every burst has full PRE and POST; no chaining logic synthesised.

Reset
REQ-024 reset=0 sampled at an edge -> state IDLE, wr_ack=0, busy=0, dqs_oe_n all 1, dqs_rst all 1, counter 0, captured registers 0.
REQ-025 Reset mid-burst takes effect at that edge regardless of state; no postamble is generated; the aborted request is not re-issued internally.

Structure
REQ-026 Package ddr2_v4_dqs_pkg holds the state enum, the BL4/BL8 toggle-count constants (2, 4) and the counter width constant.
REQ-027 Sub-module ddr2_v4_dqs_lane_drv (one per lane, generate loop) holds the oe_n/rst output flops, driven by decoded state phase and its mask bit.
REQ-028 Elaboration error if PRE_CYC or POST_CYC is outside 1..7 or DQS_WIDTH < 1.

Verification
REQ-029 DQS_WIDTH=2, PRE=1, POST=1, mask=2'b11, bl8=0, wr_req at cycle 0 -> wr_ack cycle 1; oe_n=00 cycles 1-4; rst=11,00,00,11 in cycles 1..4; IDLE cycle 5.
REQ-030 mask=2'b01, bl8=1, PRE=2, POST=2 -> lane1 oe_n=1 always; lane0 oe_n=0 for 8 cycles, rst=0 exactly cycles 3-6 after accept.
REQ-031 wr_req held through a busy burst (no macro) -> second wr_ack exactly one cycle after first burst returns to IDLE, with busy=0 for that 1 cycle.
REQ-032 reset=0 asserted in the second TOGGLE cycle -> next edge all oe_n=1, rst=1, busy=0, wr_ack=0.
REQ-033 DQS_BACK_TO_BACK_EN, BL4 then BL8, same mask, second req in last TOGGLE cycle -> 6 consecutive rst=0 cycles, one PRE, one POST, two wr_ack pulses.
REQ-034 lane_mask=0 request -> wr_ack, busy high for PRE+2+POST cycles, all oe_n stay 1.
